// File: rtl/fp32_uart_pkg.sv
// Shared UART types and constants for the FP32 serial link.
// Used by both the receiver and the transmitter.
package fp32_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int DATA_BITS      = 8;

  function automatic int clks_per_bit(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/fp32_uart_rx_if.sv
// Word output handshake between the receiver and its consumer.
interface fp32_uart_rx_if;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i;

  modport master (
    output word_o,
    output word_valid_o,
    input  word_ready_i
  );

  modport slave (
    input  word_o,
    input  word_valid_o,
    output word_ready_i
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, start/data/stop FSM.
// Emits one-cycle byte_valid_o or frame_err_o pulses.
module uart_rx_byte
  import fp32_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic       idle_o
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  rx_state_e r_state, w_state_n;
  logic [2:0]    r_sync;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [7:0]    r_shift, w_shift_n;
  logic          r_bv, w_bv_n;
  logic          r_fe, w_fe_n;
  logic          w_rx, w_fall;

  // r_sync[2] is the previous synchronized value, for edge detection
  assign w_rx   = r_sync[1];
  assign w_fall = r_sync[2] & ~r_sync[1];

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + CW'(1);
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_bv_n    = 1'b0;
    w_fe_n    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_n = '0;
        w_bit_n = '0;
        if (w_fall) w_state_n = ST_START;
      end
      ST_START: begin
        if (r_cnt == CW'(HALF - 1)) begin
          w_cnt_n   = '0;
          w_state_n = w_rx ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
          w_cnt_n   = '0;
          w_shift_n = {w_rx, r_shift[7:1]};
          w_bit_n   = r_bit + 3'd1;
          if (r_bit == 3'(DATA_BITS - 1))
            w_state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
          w_cnt_n   = '0;
          w_state_n = ST_IDLE;
          w_bv_n    = w_rx;
          w_fe_n    = ~w_rx;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync  <= 3'b111;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_bv    <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      r_sync  <= {r_sync[1:0], rx_i};
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_bv    <= w_bv_n;
      r_fe    <= w_fe_n;
    end
  end

  assign byte_o       = r_shift;
  assign byte_valid_o = r_bv;
  assign frame_err_o  = r_fe;
  assign idle_o       = (r_state == ST_IDLE);

endmodule

// File: rtl/fp32_uart_rx.sv
// FP32 word receiver: packs 4 UART bytes LSB-first into a held word.
// Optional inter-byte timeout: define FP32_UART_RX_TIMEOUT_EN.
module fp32_uart_rx
  import fp32_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             uart_rx_i,
  fp32_uart_rx_if.master   word_if,
  output logic             frame_err_o,
  output logic             overrun_o,
  output logic             timeout_o
);

  localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);

  logic [7:0]  w_byte;
  logic        w_bv, w_fe, w_idle;
  logic        w_accept, w_last, w_tmo_hit;
  logic [1:0]  r_idx;
  logic [23:0] r_acc;
  logic [31:0] r_word;
  logic        r_valid, r_ovr;

  uart_rx_byte #(
    .CLKS_PER_BIT (CPB)
  ) u_byte (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_i         (uart_rx_i),
    .byte_o       (w_byte),
    .byte_valid_o (w_bv),
    .frame_err_o  (w_fe),
    .idle_o       (w_idle)
  );

  assign w_accept = r_valid & word_if.word_ready_i;
  assign w_last   = (r_idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx   <= '0;
      r_acc   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_accept) r_valid <= 1'b0;
      if (w_fe) begin
        r_idx <= '0;
      end else if (w_bv) begin
        r_idx <= r_idx + 2'd1;
        if (!w_last) begin
          case (r_idx)
            2'd0:    r_acc[7:0]   <= w_byte;
            2'd1:    r_acc[15:8]  <= w_byte;
            default: r_acc[23:16] <= w_byte;
          endcase
        end else if (!r_valid || w_accept) begin
          r_word  <= {w_byte, r_acc};
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (w_tmo_hit) begin
        r_idx <= '0;
      end
    end
  end

`ifdef FP32_UART_RX_TIMEOUT_EN
  localparam int TMO_CLKS = TIMEOUT_BITS * CPB;

  logic [31:0] r_gap;
  logic        r_tmo;
  logic        w_gap_run;

  // gap only runs while a partial word is pending and the line is idle
  assign w_gap_run = w_idle & (r_idx != 2'd0) & ~w_bv;
  assign w_tmo_hit = w_gap_run & (r_gap == 32'(TMO_CLKS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_gap <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_tmo <= w_tmo_hit;
      if (!w_gap_run || w_tmo_hit) r_gap <= '0;
      else                         r_gap <= r_gap + 32'd1;
    end
  end

  assign timeout_o = r_tmo;
`else
  logic w_unused_idle;
  assign w_unused_idle = w_idle;
  assign w_tmo_hit     = 1'b0;
  assign timeout_o     = 1'b0;
`endif

  assign word_if.word_o       = r_word;
  assign word_if.word_valid_o = r_valid;
  assign frame_err_o          = w_fe;
  assign overrun_o            = r_ovr;

endmodule

// File: tb/tb_fp32_uart_rx.sv
// Self-checking bench for fp32_uart_rx, scoreboard of expected words.
// Timeout scenario runs only with FP32_UART_RX_TIMEOUT_EN defined.
module tb_fp32_uart_rx;

  localparam int CLK_HZ = 23_961_600;
  localparam int BAUD   = 115_200;
  localparam int TBITS  = 16;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int WAITC  = 12 * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic ferr, ovr, tmo;

  fp32_uart_rx_if wif();

  fp32_uart_rx #(
    .CLK_FREQ_HZ  (CLK_HZ),
    .BAUD_RATE    (BAUD),
    .TIMEOUT_BITS (TBITS)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .uart_rx_i   (rx),
    .word_if     (wif),
    .frame_err_o (ferr),
    .overrun_o   (ovr),
    .timeout_o   (tmo)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int n_checks = 0, n_pass = 0;
  int n_vcyc = 0, n_ferr = 0, n_ovr = 0, n_tmo = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wif.word_valid_o) n_vcyc++;
      if (wif.word_valid_o && wif.word_ready_i)
        got_q.push_back(wif.word_o);
      if (ferr) n_ferr++;
      if (ovr)  n_ovr++;
      if (tmo)  n_tmo++;
    end
  end

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 wif.word_ready_i = v;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic wait_got(input int n, output bit ok);
    int t = 0;
    while (got_q.size() < n && t < WAITC) begin
      @(negedge clk);
      t++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset;
    logic [35:0] o;
    rst_n = 1'b0;
    wif.word_ready_i = 1'b0;
    repeat (5) @(negedge clk);
    o = {wif.word_o, wif.word_valid_o, ferr, ovr, tmo};
    n_checks++;
    if (o !== 36'd0) $display("FAIL reset_in got %h want 0", o);
    else n_pass++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    o = {wif.word_o, wif.word_valid_o, ferr, ovr, tmo};
    n_checks++;
    if (o !== 36'd0) $display("FAIL reset_out got %h want 0", o);
    else n_pass++;
  endtask

  task automatic test_basic;
    int v0, f0;
    bit ok;
    logic [31:0] e, g;
    set_ready(1'b1);
    v0 = n_vcyc;
    f0 = n_ferr;
    exp_q.push_back(32'h4443_4241);
    send_word(32'h4443_4241);
    wait_got(1, ok);
    repeat (5) @(negedge clk);
    if (!ok) begin
      n_checks++;
      $display("FAIL basic_word no word got 0 want 1");
      exp_q.delete();
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) $display("FAIL basic_word got %h want %h", g, e);
      else n_pass++;
    end
    n_checks++;
    if (n_vcyc - v0 !== 1)
      $display("FAIL basic_vcyc got %0d want 1", n_vcyc - v0);
    else n_pass++;
    n_checks++;
    if (n_ferr - f0 !== 0)
      $display("FAIL basic_ferr got %0d want 0", n_ferr - f0);
    else n_pass++;
  endtask

  task automatic test_glitch;
    int f0;
    bit ok;
    logic [31:0] e, g;
    f0 = n_ferr;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_checks++;
    if (n_ferr - f0 !== 0 || got_q.size() !== 0)
      $display("FAIL glitch_quiet got ferr=%0d words=%0d want 0/0",
               n_ferr - f0, got_q.size());
    else n_pass++;
    exp_q.push_back(32'hC2F6_E979);
    send_word(32'hC2F6_E979);
    wait_got(1, ok);
    if (!ok) begin
      n_checks++;
      $display("FAIL glitch_word no word got 0 want 1");
      exp_q.delete();
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) $display("FAIL glitch_word got %h want %h", g, e);
      else n_pass++;
    end
  endtask

  task automatic test_frame_err;
    int f0;
    bit ok;
    logic [31:0] e, g;
    f0 = n_ferr;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    repeat (CPB) @(negedge clk);
    n_checks++;
    if (n_ferr - f0 !== 1)
      $display("FAIL ferr_pulse got %0d want 1", n_ferr - f0);
    else n_pass++;
    n_checks++;
    if (got_q.size() !== 0)
      $display("FAIL ferr_noword got %0d want 0", got_q.size());
    else n_pass++;
    exp_q.push_back(32'h3F80_0000);
    send_word(32'h3F80_0000);
    wait_got(1, ok);
    if (!ok) begin
      n_checks++;
      $display("FAIL ferr_word no word got 0 want 1");
      exp_q.delete();
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) $display("FAIL ferr_word got %h want %h", g, e);
      else n_pass++;
    end
  endtask

  task automatic test_overrun;
    int o0;
    bit ok;
    logic [31:0] e, g;
    set_ready(1'b0);
    o0 = n_ovr;
    exp_q.push_back(32'h4049_0FDB);
    send_word(32'h4049_0FDB);
    send_word(32'hC000_0000);
    repeat (10) @(negedge clk);
    n_checks++;
    if (wif.word_valid_o !== 1'b1)
      $display("FAIL ovr_valid got %b want 1", wif.word_valid_o);
    else n_pass++;
    n_checks++;
    if (wif.word_o !== 32'h4049_0FDB)
      $display("FAIL ovr_held got %h want 40490fdb", wif.word_o);
    else n_pass++;
    n_checks++;
    if (n_ovr - o0 !== 1)
      $display("FAIL ovr_pulse got %0d want 1", n_ovr - o0);
    else n_pass++;
    n_checks++;
    if (got_q.size() !== 0)
      $display("FAIL ovr_noaccept got %0d want 0", got_q.size());
    else n_pass++;
    set_ready(1'b1);
    wait_got(1, ok);
    repeat (3) @(negedge clk);
    if (!ok) begin
      n_checks++;
      $display("FAIL ovr_word no word got 0 want 1");
      exp_q.delete();
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) $display("FAIL ovr_word got %h want %h", g, e);
      else n_pass++;
    end
    n_checks++;
    if (wif.word_valid_o !== 1'b0 || got_q.size() !== 0)
      $display("FAIL ovr_drop got v=%b n=%0d want 0/0",
               wif.word_valid_o, got_q.size());
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    logic [35:0] o;
    bit ok;
    logic [31:0] e, g;
    logic [7:0] b;
    b = 8'h5A;
    send_byte(8'hAA, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    o = {wif.word_o, wif.word_valid_o, ferr, ovr, tmo};
    n_checks++;
    if (o !== 36'd0) $display("FAIL midrst_out got %h want 0", o);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back(32'h1234_5678);
    send_word(32'h1234_5678);
    wait_got(1, ok);
    if (!ok) begin
      n_checks++;
      $display("FAIL midrst_word no word got 0 want 1");
      exp_q.delete();
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) $display("FAIL midrst_word got %h want %h", g, e);
      else n_pass++;
    end
  endtask

  task automatic test_gap;
    int t0;
    bit ok;
    logic [31:0] e, g;
    t0 = n_tmo;
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    repeat (20 * CPB) @(negedge clk);
`ifdef FP32_UART_RX_TIMEOUT_EN
    n_checks++;
    if (n_tmo - t0 !== 1)
      $display("FAIL gap_tmo got %0d want 1", n_tmo - t0);
    else n_pass++;
    exp_q.push_back(32'h0403_0201);
    send_word(32'h0403_0201);
`else
    n_checks++;
    if (n_tmo - t0 !== 0)
      $display("FAIL gap_tmo got %0d want 0", n_tmo - t0);
    else n_pass++;
    exp_q.push_back(32'hEFBE_ADDE);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
`endif
    wait_got(1, ok);
    if (!ok) begin
      n_checks++;
      $display("FAIL gap_word no word got 0 want 1");
      exp_q.delete();
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) $display("FAIL gap_word got %h want %h", g, e);
      else n_pass++;
    end
  endtask

  initial begin
    wif.word_ready_i = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_mid_reset();
    test_gap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp32_uart_rx.md
FP32_UART_RX -- requirements
Module: fp32_uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, line bit rate.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 16, inter-byte gap limit in bit-times.
REQ-004 clk_i  input  1  system clock, all logic on rising edge.
REQ-005 rst_ni  input  1  reset; one clock, asynchronous assert, active-low.
REQ-006 uart_rx_i  input  1  asynchronous serial line, idle high, 8N1.
REQ-007 word_o  output  32  assembled FP32 word.
REQ-008 word_valid_o  output  1  word_o valid; held until accepted.
REQ-009 word_ready_i  input  1  consumer accepts word when valid and ready are both high on a rising edge.
REQ-010 frame_err_o  output  1  one-cycle pulse on bad stop bit.
REQ-011 overrun_o  output  1  one-cycle pulse when a completed word is dropped.
REQ-012 timeout_o  output  1  one-cycle pulse on inter-byte timeout.

Function
REQ-013 uart_rx_i SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-014 Bit period SHALL be CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (434 at defaults); half period = CLKS_PER_BIT/2 (217).
REQ-015 Byte FSM states SHALL be IDLE, START, DATA, STOP.
REQ-016 IDLE->START on synchronized high-to-low transition; clock counter cleared.
REQ-017 START: after half period, line low -> DATA; line high -> IDLE (glitch rejected, nothing reported).
REQ-018 DATA: SHALL sample once per full period, 8 bits LSB first; after bit 7 -> STOP.
REQ-019 STOP: after one full period, sample the line; high -> byte accepted; low -> frame_err_o pulse; both -> IDLE.
REQ-020 Byte n (0..3) SHALL fill word bits [8n+7:8n]; first received byte is bits [7:0].
REQ-021 Frame error SHALL discard the partial word and reset byte index to 0.
REQ-022 On acceptance of byte 3 SHALL load word_o and raise word_valid_o on the next clock edge; byte index wraps to 0.
REQ-023 word_valid_o SHALL stay high and word_o stable until the handshake; it deasserts the clock after acceptance.
REQ-024 Word completing while word_valid_o high and not accepted in that cycle SHALL be dropped; overrun_o pulses; held word unchanged.
REQ-025 Handshake and completion in the same cycle SHALL load the new word and keep word_valid_o high; no overrun.
REQ-026 Reception SHALL continue independent of word_ready_i; no backpressure to the line.

Reset
REQ-027 rst_ni low SHALL force FSM to IDLE, all counters and byte index to 0, synchronizer flops to 1, word_o to 0, all pulse outputs and word_valid_o to 0.
REQ-028 Reset mid-byte or mid-word SHALL discard all partial data; first falling edge after release starts a new byte 0.

Configuration
REQ-029 With FP32_UART_RX_TIMEOUT_EN defined: in IDLE with byte index nonzero, a gap of TIMEOUT_BITS*CLKS_PER_BIT clocks SHALL discard the partial word, reset byte index to 0, pulse timeout_o.
REQ-030 Without FP32_UART_RX_TIMEOUT_EN: no timeout counter; partial words persist indefinitely; timeout_o tied 0.

Structure
REQ-031 Package fp32_uart_pkg SHALL hold the byte FSM state enum, BYTES_PER_WORD = 4, DATA_BITS = 8, and the CLKS_PER_BIT derivation function, shared with the transmitter.
REQ-032 Sub-module uart_rx_byte SHALL contain synchronizer, byte FSM, and emit byte/byte_valid/frame_err; fp32_uart_rx contains word assembly, handshake, and timeout.

Verification
REQ-033 Bytes 0x41,0x42,0x43,0x44 at 115200, word_ready_i=1 -> word_o=32'h4443_4241, word_valid_o high exactly one cycle.
REQ-034 Line low for 100 clocks then high -> no byte, no frame_err_o; following 4 clean bytes produce the correct word.
REQ-035 Byte 2 with stop bit 0 -> one frame_err_o pulse, no word; next 0x00,0x00,0x80,0x3F -> word_o=32'h3F80_0000.
REQ-036 word_ready_i=0, two full words sent -> first word held, one overrun_o pulse; ready raised -> first word accepted.
REQ-037 (TIMEOUT_EN) two bytes, then 20 bit-times idle -> timeout_o pulse; next 4 bytes produce word from those bytes only.
REQ-038 rst_ni pulsed low during DATA of byte 1 -> all outputs 0 immediately; next 4 bytes produce a correct word.
